// File: rtl/fetch_redirect_pkg.sv
// -----------------------------------------------------------------------------
// fetch_redirect_pkg
// Shared definitions for the fetch-redirect slice: datapath word width, the
// redirect state encoding and a helper that word-aligns a fetch address.
// -----------------------------------------------------------------------------
package fetch_redirect_pkg;

  localparam int unsigned WORD_LEN = 32;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } redirect_state_t;

  // Force an address onto a 4-byte boundary; the low two bits of a branch
  // target never reach the PC.
  function automatic logic [WORD_LEN-1:0] align_word(input logic [WORD_LEN-1:0] addr);
    return {addr[WORD_LEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_redirect_pc_register.sv
// -----------------------------------------------------------------------------
// pc_register
// Program-counter register with asynchronous active-high reset to zero and a
// load enable.
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset, clears the register
//   i_en   - load enable; when low the register holds
//   i_d    - next PC value
//   o_q    - current PC value
// -----------------------------------------------------------------------------
module pc_register
  import fetch_redirect_pkg::*;
#(
  parameter int unsigned W = WORD_LEN
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // NOTE: clocked state is always written with non-blocking assignments so
  // every register samples its inputs from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_redirect.sv
// -----------------------------------------------------------------------------
// fetch_redirect
// IF-stage next-PC logic. Advances the PC by 4 each unstalled cycle, applies a
// taken branch from ID one edge later, and remembers a branch that resolves
// while the hazard unit is stalling so it is applied as soon as the stall ends.
// The first target captured during a stall wins.
//
// Configuration macro: DELAY_SLOT_EN
//   defined   - flush is tied low, the instruction in IF at redirect time
//               (the delay slot) executes.
//   undefined - flush pulses in every cycle in which a redirect is applied.
//   PC sequencing is the same in both builds.
//
// Ports:
//   clk             - clock, rising edge
//   rst             - asynchronous active-high reset (pc=0, state RUN)
//   freeze          - stall; PC holds while high
//   brTaken         - resolved branch/jump condition from ID
//   brTarget        - branch/jump target from ID (low two bits ignored)
//   pc              - current fetch address
//   pcPlus4         - pc + 4, to IF/ID
//   flush           - clear IF/ID at the next edge
//   redirectPending - a stalled redirect is waiting to be applied
// -----------------------------------------------------------------------------
module fetch_redirect
  import fetch_redirect_pkg::*;
#(
  parameter int unsigned WORD_LEN = fetch_redirect_pkg::WORD_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                brTaken,
  input  logic [WORD_LEN-1:0] brTarget,
  output logic [WORD_LEN-1:0] pc,
  output logic [WORD_LEN-1:0] pcPlus4,
  output logic                flush,
  output logic                redirectPending
);

  redirect_state_t     r_state;
  redirect_state_t     w_state_next;
  logic [WORD_LEN-1:0] r_saved_target;
  logic [WORD_LEN-1:0] w_pc;
  logic [WORD_LEN-1:0] w_pc_plus4;
  logic [WORD_LEN-1:0] w_pc_next;
  logic [WORD_LEN-1:0] w_br_aligned;
  logic                w_pc_en;
  logic                w_capture;
  logic                w_redirect;

  assign w_br_aligned = {brTarget[WORD_LEN-1:2], 2'b00};
  // Increment wraps naturally at the word width.
  assign w_pc_plus4   = w_pc + WORD_LEN'(4);

  pc_register #(
    .W (WORD_LEN)
  ) u_pc_register (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_pc_en),
    .i_d  (w_pc_next),
    .o_q  (w_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= RUN;
      r_saved_target <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_capture) begin
        r_saved_target <= w_br_aligned;
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = w_pc_plus4;
    w_pc_en      = 1'b0;
    w_capture    = 1'b0;
    w_redirect   = 1'b0;
    unique case (r_state)
      RUN: begin
        if (!freeze) begin
          w_pc_en = 1'b1;
          if (brTaken) begin
            w_pc_next  = w_br_aligned;
            w_redirect = 1'b1;
          end
        end else if (brTaken) begin
          w_capture    = 1'b1;
          w_state_next = PEND;
        end
      end
      PEND: begin
        // brTaken is ignored here: the target captured on entry wins.
        if (!freeze) begin
          w_pc_en      = 1'b1;
          w_pc_next    = r_saved_target;
          w_redirect   = 1'b1;
          w_state_next = RUN;
        end
      end
      default: begin
        w_state_next = RUN;
      end
    endcase
  end

  assign pc              = w_pc;
  assign pcPlus4         = w_pc_plus4;
  assign redirectPending = (r_state == PEND);

`ifdef DELAY_SLOT_EN
  assign flush = 1'b0;
  logic w_unused_redirect;
  assign w_unused_redirect = w_redirect;
`else
  assign flush = w_redirect;
`endif

endmodule

// File: tb/tb_fetch_redirect.sv
// -----------------------------------------------------------------------------
// tb_fetch_redirect
// Directed self-checking bench for fetch_redirect. Inputs change 1 ns after a
// rising edge; outputs are sampled 1-2 ns after an edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fetch_redirect;

  localparam int unsigned W = 32;

`ifdef DELAY_SLOT_EN
  localparam logic EXP_FLUSH = 1'b0;
`else
  localparam logic EXP_FLUSH = 1'b1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         freeze;
  logic         brTaken;
  logic [W-1:0] brTarget;
  logic [W-1:0] pc;
  logic [W-1:0] pcPlus4;
  logic         flush;
  logic         redirectPending;

  int n_checks = 0;
  int n_errors = 0;

  fetch_redirect #(
    .WORD_LEN (W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .freeze          (freeze),
    .brTaken         (brTaken),
    .brTarget        (brTarget),
    .pc              (pc),
    .pcPlus4         (pcPlus4),
    .flush           (flush),
    .redirectPending (redirectPending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to 1 ns past the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fetch sequence 0x0 -> 0x10 then a taken branch to 0x40, then 0x44.
  task automatic run_branch_scenario(input string tag);
    check({tag, " pc0"}, pc, 32'h0);
    check({tag, " flush0"}, {31'b0, flush}, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("%s pc%0d", tag, i), pc, 32'(4 * i));
      check($sformatf("%s flush%0d", tag, i), {31'b0, flush}, 32'h0);
    end
    brTaken  = 1'b1;
    brTarget = 32'h40;
    #1;
    check({tag, " br flush"}, {31'b0, flush}, {31'b0, EXP_FLUSH});
    step();
    brTaken = 1'b0;
    #1;
    check({tag, " br pc"}, pc, 32'h40);
    check({tag, " post br flush"}, {31'b0, flush}, 32'h0);
    step();
    check({tag, " pc after br"}, pc, 32'h44);
  endtask

  initial begin
    rst      = 1'b1;
    freeze   = 1'b0;
    brTaken  = 1'b0;
    brTarget = '0;
    #2;
    check("reset pc", pc, 32'h0);
    check("reset pending", {31'b0, redirectPending}, 32'h0);
    check("reset flush", {31'b0, flush}, 32'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;

    // Sequential fetch plus a single unstalled branch.
    run_branch_scenario("seq");

    // Branch resolved during a 3-cycle stall; target changes mid-stall.
    freeze   = 1'b1;
    brTaken  = 1'b1;
    brTarget = 32'h80;
    #1;
    check("stall flush", {31'b0, flush}, 32'h0);
    step();
    check("stall pc1", pc, 32'h44);
    check("stall pend1", {31'b0, redirectPending}, 32'h1);
    brTarget = 32'h90;
    step();
    check("stall pc2", pc, 32'h44);
    check("stall pend2", {31'b0, redirectPending}, 32'h1);
    check("stall pend flush", {31'b0, flush}, 32'h0);
    step();
    check("stall pc3", pc, 32'h44);
    freeze  = 1'b0;
    brTaken = 1'b1;     // ignored in PEND
    #1;
    check("release flush", {31'b0, flush}, {31'b0, EXP_FLUSH});
    check("release pend", {31'b0, redirectPending}, 32'h1);
    step();
    brTaken = 1'b0;
    #1;
    check("release pc", pc, 32'h80);
    check("release pend clr", {31'b0, redirectPending}, 32'h0);

    // Wrap at the top of the address space.
    brTaken  = 1'b1;
    brTarget = 32'hFFFF_FFFC;
    step();
    brTaken = 1'b0;
    #1;
    check("wrap pc", pc, 32'hFFFF_FFFC);
    check("wrap pcPlus4", pcPlus4, 32'h0);
    step();
    check("wrap pc next", pc, 32'h0);
    check("pcPlus4 at 0", pcPlus4, 32'h4);

    // Misaligned target is forced to a word boundary.
    brTaken  = 1'b1;
    brTarget = 32'h47;
    step();
    brTaken = 1'b0;
    #1;
    check("align pc", pc, 32'h44);

    // Reset in PEND discards the pending target.
    freeze   = 1'b1;
    brTaken  = 1'b1;
    brTarget = 32'h100;
    step();
    check("pre-rst pend", {31'b0, redirectPending}, 32'h1);
    #1 rst = 1'b1;
    #1;
    check("mid rst pc", pc, 32'h0);
    check("mid rst pend", {31'b0, redirectPending}, 32'h0);
    check("mid rst flush", {31'b0, flush}, 32'h0);
    rst     = 1'b0;
    freeze  = 1'b0;
    brTaken = 1'b0;
    #1;
    check("post rst flush", {31'b0, flush}, 32'h0);
    step();
    check("post rst pc", pc, 32'h4);
    step();
    check("post rst pc2", pc, 32'h8);

    // Restart from zero and repeat the branch scenario.
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    run_branch_scenario("rerun");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
